// File: rtl/fetch_ctrl.sv
// PC and run control: IDLE -> RUN -> DONE, relative branches, saturating retire count.
// Optional BR_COUNT_EN adds a saturating taken-branch counter on BrTaken.
module fetch_ctrl #(
    parameter int unsigned           PC_W      = 8,
    parameter int unsigned           OFF_W     = 6,
    parameter int unsigned           CNT_W     = 16,
    parameter logic [PC_W-1:0]       HALT_ADDR = {PC_W{1'b1}}
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  Start_Addr,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Zero,
    input  logic [OFF_W-1:0] Offset,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
`ifdef BR_COUNT_EN
    output logic [CNT_W-1:0] BrTaken,
`endif
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    off_sext;
    logic               taken;
    logic               step;

    assign off_sext = {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset};
    assign taken    = Branch & Zero;
    // An executing slot: running, not stalled, and not sitting on the halt address.
    assign step     = (state_q == RUN) && !Stall && (pc_q != HALT_ADDR);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (Start) begin
            state_d = RUN;
            pc_d    = Start_Addr;
            cnt_d   = '0;
        end else if (state_q == RUN && !Stall) begin
            if (pc_q == HALT_ADDR) begin
                state_d = DONE;
            end else begin
                pc_d  = taken ? pc_q + off_sext : pc_q + PC_W'(1);
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BR_COUNT_EN
    logic [CNT_W-1:0] br_q, br_d;

    always_comb begin
        br_d = br_q;
        if (Start) begin
            br_d = '0;
        end else if (step && taken && !(&br_q)) begin
            br_d = br_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            br_q <= '0;
        end else begin
            br_q <= br_d;
        end
    end

    assign BrTaken = br_q;
`else
    logic unused_step;
    assign unused_step = step;
`endif

    assign PC         = pc_q;
    assign InstrCount = cnt_q;
    assign Running    = (state_q == RUN);
    assign Done       = (state_q == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed checks of fetch_ctrl, default width and a 4-bit counter instance.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [7:0]  Start_Addr;
    logic        Stall;
    logic        Branch;
    logic        Zero;
    logic [5:0]  Offset;

    logic [7:0]  PC, PC4;
    logic        Running, Running4;
    logic        Done, Done4;
    logic [15:0] InstrCount;
    logic [3:0]  InstrCount4;
`ifdef BR_COUNT_EN
    logic [15:0] BrTaken;
    logic [3:0]  BrTaken4;
`endif

    int errs = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fetch_ctrl dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Start_Addr(Start_Addr),
        .Stall(Stall), .Branch(Branch), .Zero(Zero), .Offset(Offset),
        .PC(PC), .Running(Running), .Done(Done),
`ifdef BR_COUNT_EN
        .BrTaken(BrTaken),
`endif
        .InstrCount(InstrCount)
    );

    fetch_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Start_Addr(Start_Addr),
        .Stall(Stall), .Branch(Branch), .Zero(Zero), .Offset(Offset),
        .PC(PC4), .Running(Running4), .Done(Done4),
`ifdef BR_COUNT_EN
        .BrTaken(BrTaken4),
`endif
        .InstrCount(InstrCount4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] addr);
        Start_Addr = addr;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Start_Addr = '0; Stall = 1'b0;
        Branch = 1'b0; Zero = 1'b0; Offset = '0;
        tick(2);
        chk("rst_pc", PC, 0);
        chk("rst_run", Running, 0);
        chk("rst_done", Done, 0);
        chk("rst_cnt", InstrCount, 0);
        Reset_n = 1'b1;
        tick(2);
        chk("idle_hold_pc", PC, 0);
        chk("idle_hold_run", Running, 0);

        // Linear run to halt
        pulse_start(8'hF0);
        chk("f0_pc", PC, 8'hF0);
        chk("f0_run", Running, 1);
        chk("f0_cnt", InstrCount, 0);
        tick(15);
        chk("ff_pc", PC, 8'hFF);
        chk("ff_cnt", InstrCount, 15);
        chk("ff_done_pre", Done, 0);
        tick();
        chk("halt_done", Done, 1);
        chk("halt_run", Running, 0);
        chk("halt_pc", PC, 8'hFF);
        chk("halt_cnt", InstrCount, 15);
        tick(2);
        chk("done_hold_pc", PC, 8'hFF);
        chk("done_hold", Done, 1);

        // Taken and not-taken branch
        pulse_start(8'h10);
        Branch = 1'b1; Zero = 1'b1; Offset = 6'b111100;
        tick();
        chk("br_taken_pc", PC, 8'h0C);
        chk("br_taken_cnt", InstrCount, 1);
        Branch = 1'b0; Zero = 1'b0;
        pulse_start(8'h10);
        Branch = 1'b1; Zero = 1'b0;
        tick();
        chk("br_nt_pc", PC, 8'h11);

        // Backward wrap into halt
        pulse_start(8'h02);
        Zero = 1'b1;
        tick();
        chk("wrap_pc", PC, 8'hFE);
        Branch = 1'b0; Zero = 1'b0;
        tick();
        chk("wrap_pc2", PC, 8'hFF);
        tick();
        chk("wrap_done", Done, 1);
        chk("wrap_cnt", InstrCount, 2);

        // Stall holds
        pulse_start(8'h40);
        Stall = 1'b1;
        tick(3);
        chk("stall_pc", PC, 8'h40);
        chk("stall_cnt", InstrCount, 0);
        chk("stall_run", Running, 1);
        Stall = 1'b0;
        tick();
        chk("unstall_pc", PC, 8'h41);
        chk("unstall_cnt", InstrCount, 1);

        // Asynchronous reset mid-run
        pulse_start(8'h20);
        tick(3);
        chk("pre_rst_pc", PC, 8'h23);
        Reset_n = 1'b0;
        #1;
        chk("arst_pc", PC, 0);
        chk("arst_run", Running, 0);
        chk("arst_done", Done, 0);
        chk("arst_cnt", InstrCount, 0);
        tick();
        Reset_n = 1'b1;
        tick(3);
        chk("post_rst_pc", PC, 0);
        chk("post_rst_run", Running, 0);

        // Start on the halt address
        pulse_start(8'hFF);
        chk("sh_run", Running, 1);
        tick();
        chk("sh_done", Done, 1);
        chk("sh_cnt", InstrCount, 0);

        // Spin loop, saturation, branch onto halt, restart from DONE
        pulse_start(8'hF0);
        Branch = 1'b1; Zero = 1'b1; Offset = 6'd0;
        tick(20);
        chk("spin_pc", PC, 8'hF0);
        chk("spin_cnt16", InstrCount, 20);
        chk("spin_cnt4", InstrCount4, 15);
        Offset = 6'd15;
        tick();
        chk("bt_halt_pc", PC, 8'hFF);
        chk("bt_halt_run", Running, 1);
        Branch = 1'b0; Zero = 1'b0;
        tick();
        chk("bt_done", Done, 1);
        chk("bt_done4", Done4, 1);
        chk("bt_cnt16", InstrCount, 21);
        chk("bt_cnt4", InstrCount4, 15);
`ifdef BR_COUNT_EN
        chk("br16", BrTaken, 21);
        chk("br4", BrTaken4, 15);
`endif
        pulse_start(8'h00);
        chk("restart_cnt4", InstrCount4, 0);
        chk("restart_done4", Done4, 0);
        chk("restart_pc", PC, 0);
`ifdef BR_COUNT_EN
        chk("restart_br4", BrTaken4, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
